aes_key_expand: RTL

Iterative AES-128 key-expansion engine producing the eleven round keys (rounds 0–10) from a 128-bit cipher key, one round key per clock. It sits upstream of the round datapath (AddRoundKey) and instantiates four `SBox` lookups to implement SubWord. Each round key is presented with a valid strobe and its round index, so the cipher core can consume keys on the fly or latch them.

---
 rtl/aes_key_expand.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key expansion: one round key (0..10) per clock after an accepted start.
// Optional AES_KEYEXP_STORE_EN adds an 11-entry round-key store with a registered read port.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] xtime8(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (y[i] ? xx : 8'h00);
      xx = xtime8(xx);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; zero maps to zero naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign s = affine(gf_inv(a));

endmodule

module aes_key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_round,
  output logic [127:0] rk_out,
  output logic         done
`ifdef AES_KEYEXP_STORE_EN
  ,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_EXPAND = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [31:0]  rot_word_s;
  logic [31:0]  sub_word_s;
  logic [127:0] next_key_s;

  // RotWord of w3 (the least significant word of the current key)
  assign rot_word_s = {key_q[23:0], key_q[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot_word_s[8*gi +: 8]),
      .s (sub_word_s[8*gi +: 8])
    );
  end

  // Next round key from the current one
  always_comb begin
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub_word_s ^ {rcon_q, 24'h000000};
    w0 = key_q[127:96] ^ t;
    w1 = key_q[95:64]  ^ w0;
    w2 = key_q[63:32]  ^ w1;
    w3 = key_q[31:0]   ^ w2;
    next_key_s = {w0, w1, w2, w3};
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_EXPAND;
          key_d   = key_in;
          round_d = 4'd0;
          rcon_d  = 8'h01;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXPAND: begin
        if (round_q < 4'd10) begin
          key_d   = next_key_s;
          round_d = round_q + 4'd1;
          rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = (round_q == 4'd9);
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Core state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= 128'd0;
      round_q <= 4'd0;
      rcon_q  <= 8'h01;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = valid_q;
  assign rk_round = round_q;
  assign rk_out   = key_q;
  assign done     = done_q;

`ifdef AES_KEYEXP_STORE_EN
  logic [127:0] store_q [0:10];
  logic [127:0] store_d [0:10];
  logic [127:0] rd_key_q, rd_key_d;

  // Capture each round key while it is valid; the read sees pre-write contents
  always_comb begin
    rd_key_d = 128'd0;
    for (int i = 0; i < 11; i++) begin
      store_d[i] = (valid_q && (round_q == 4'(i))) ? key_q : store_q[i];
      rd_key_d   = (rd_addr == 4'(i)) ? store_q[i] : rd_key_d;
    end
  end

  // Key store and registered read data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) begin
        store_q[i] <= 128'd0;
      end
      rd_key_q <= 128'd0;
    end else begin
      for (int i = 0; i < 11; i++) begin
        store_q[i] <= store_d[i];
      end
      rd_key_q <= rd_key_d;
    end
  end

  assign rd_key = rd_key_q;
`endif

endmodule
